// File: rtl/param_updn_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updn_counter
// Purpose  : Parameterised up/down counter with a programmable terminal
//            count, selectable wrap/saturate behaviour at the boundaries,
//            a synchronous parallel load and registered boundary pulses.
// Revision : 1.0 - initial release
//
// Parameters
//   WIDTH      counter width in bits (2..32)
//   MAX_VAL    terminal count (1..2**WIDTH-1), default all ones
//
// Ports
//   clk        clock, rising-edge active
//   rst        asynchronous active-low reset
//   en         count enable
//   up_dn      direction, 1 = up, 0 = down
//   sat_mode   boundary behaviour, 0 = wrap, 1 = saturate
//   load       synchronous load strobe (highest priority)
//   load_val   value to load, clamped to MAX_VAL
//   count      registered counter value, never above MAX_VAL
//   ovf        one-cycle pulse after an up-boundary event
//   udf        one-cycle pulse after a down-boundary event
//
// Optional feature (macro UPDN_CNT_STICKY_FLAG_EN)
//   flag_clr   clears the sticky flags on a rising edge
//   ovf_sticky set with every ovf pulse, held until cleared
//   udf_sticky set with every udf pulse, held until cleared
//   A new boundary event on the same edge as flag_clr keeps the flag set.
// ============================================================================
module param_updn_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             udf
`ifdef UPDN_CNT_STICKY_FLAG_EN
  ,
  input  logic             flag_clr,
  output logic             ovf_sticky,
  output logic             udf_sticky
`endif
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] load_clamped;
  logic             up_evt;
  logic             dn_evt;
  logic [WIDTH-1:0] count_nxt;

  // Loaded values above the terminal count would break the count<=MAX_VAL
  // invariant, so they are clipped to MAX_VAL.
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Boundary events only exist when counting; a load masks them.
  assign up_evt = en && !load &&  up_dn && (count == MAX_VAL);
  assign dn_evt = en && !load && !up_dn && (count == c_zero);

  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_clamped;
    end else if (en) begin
      if (up_dn) begin
        if (up_evt) begin
          count_nxt = sat_mode ? MAX_VAL : c_zero;
        end else begin
          count_nxt = count + c_one;
        end
      end else begin
        if (dn_evt) begin
          count_nxt = sat_mode ? c_zero : MAX_VAL;
        end else begin
          count_nxt = count - c_one;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= c_zero;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= up_evt;
      udf   <= dn_evt;
    end
  end

`ifdef UPDN_CNT_STICKY_FLAG_EN
  // Sticky flags rise on the same edge as the matching pulse; setting takes
  // precedence over a concurrent clear so no event can be lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (up_evt) begin
        ovf_sticky <= 1'b1;
      end else if (flag_clr) begin
        ovf_sticky <= 1'b0;
      end
      if (dn_evt) begin
        udf_sticky <= 1'b1;
      end else if (flag_clr) begin
        udf_sticky <= 1'b0;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_updn_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_updn_counter
// Purpose  : Self-checking bench for param_updn_counter (WIDTH=4, MAX_VAL=9).
//            Directed boundary scenarios plus randomized traffic, all checked
//            against a behavioural model of the counter rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_updn_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         sat_mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         ovf;
  logic         udf;
`ifdef UPDN_CNT_STICKY_FLAG_EN
  logic         flag_clr;
  logic         ovf_sticky;
  logic         udf_sticky;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int m_cnt;
  bit m_ovf;
  bit m_udf;
  bit m_ovs;
  bit m_uds;

  param_updn_counter #(
    .WIDTH   (W),
    .MAX_VAL (4'(MAXV))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .sat_mode (sat_mode),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .ovf      (ovf),
    .udf      (udf)
`ifdef UPDN_CNT_STICKY_FLAG_EN
    ,
    .flag_clr   (flag_clr),
    .ovf_sticky (ovf_sticky),
    .udf_sticky (udf_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0;
    m_ovf = 0;
    m_udf = 0;
    m_ovs = 0;
    m_uds = 0;
  endtask

  // Drive one cycle of inputs, let one rising edge pass, advance the model.
  task automatic step(input bit e, input bit u, input bit s, input bit l,
                      input int lv, input bit fc);
    bit eo;
    bit eu;
    en       = e;
    up_dn    = u;
    sat_mode = s;
    load     = l;
    load_val = W'(lv);
`ifdef UPDN_CNT_STICKY_FLAG_EN
    flag_clr = fc;
`endif
    @(posedge clk);
    #1;
    eo = 0;
    eu = 0;
    if (l) begin
      m_cnt = (lv > MAXV) ? MAXV : lv;
    end else if (e && u) begin
      if (m_cnt == MAXV) begin
        eo    = 1;
        m_cnt = s ? MAXV : 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (e) begin
      if (m_cnt == 0) begin
        eu    = 1;
        m_cnt = s ? 0 : MAXV;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    m_ovf = eo;
    m_udf = eu;
    m_ovs = eo ? 1'b1 : (fc ? 1'b0 : m_ovs);
    m_uds = eu ? 1'b1 : (fc ? 1'b0 : m_uds);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(1, 1, 0, 0, 0, 0);
    model_reset();
    n_tests++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", count);
    end
    n_tests++;
    if (ovf !== 1'b0 || udf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got ovf=%b udf=%b expected 0 0", ovf, udf);
    end
`ifdef UPDN_CNT_STICKY_FLAG_EN
    n_tests++;
    if (ovf_sticky !== 1'b0 || udf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sticky: got %b %b expected 0 0", ovf_sticky, udf_sticky);
    end
`endif
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_count();
    step(0, 1, 0, 1, 5, 0);
    step(1, 1, 0, 0, 0, 0);
    n_tests++;
    if (count !== 4'd6) begin
      n_fail++;
      $display("FAIL midrst_pre: got %0d expected 6", count);
    end
    rst = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (count !== 4'd0 || ovf !== 1'b0 || udf !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got count=%0d ovf=%b udf=%b expected 0 0 0",
               count, ovf, udf);
    end
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 0, 0, 0, 0);
      n_tests++;
      if (count !== W'(i)) begin
        n_fail++;
        $display("FAIL midrst_count%0d: got %0d expected %0d", i, count, i);
      end
    end
  endtask

  task automatic test_wrap_up();
    int exp_seq[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    step(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      step(1, 1, 0, 0, 0, 0);
      n_tests++;
      if (count !== W'(exp_seq[i]) || ovf !== (i == 9) || udf !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: got count=%0d ovf=%b udf=%b expected %0d %b 0",
                 i, count, ovf, udf, exp_seq[i], (i == 9));
      end
    end
  endtask

  task automatic test_sat_down();
    int exp_seq[4] = '{1, 0, 0, 0};
    bit exp_u[4]   = '{0, 0, 1, 1};
    step(0, 0, 1, 1, 2, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, 0, 0);
      n_tests++;
      if (count !== W'(exp_seq[i]) || udf !== exp_u[i] || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_down[%0d]: got count=%0d udf=%b ovf=%b expected %0d %b 0",
                 i, count, udf, ovf, exp_seq[i], exp_u[i]);
      end
    end
  endtask

  task automatic test_load_clamp();
    step(1, 1, 0, 1, 13, 0);
    n_tests++;
    if (count !== 4'd9 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clamp: got count=%0d ovf=%b expected 9 0", count, ovf);
    end
    step(1, 1, 0, 0, 0, 0);
    n_tests++;
    if (count !== 4'd0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL load_then_wrap: got count=%0d ovf=%b expected 0 1", count, ovf);
    end
    // load on what would have been a boundary edge suppresses the pulse
    step(1, 0, 0, 1, 4, 0);
    n_tests++;
    if (count !== 4'd4 || ovf !== 1'b0 || udf !== 1'b0) begin
      n_fail++;
      $display("FAIL load_masks_evt: got count=%0d ovf=%b udf=%b expected 4 0 0",
               count, ovf, udf);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 1, 0, 1, 9, 0);
    step(1, 1, 0, 0, 0, 0);
    n_tests++;
    if (count !== 4'd0 || ovf !== 1'b1 || udf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_up: got count=%0d ovf=%b udf=%b expected 0 1 0", count, ovf, udf);
    end
    step(1, 0, 0, 0, 0, 0);
    n_tests++;
    if (count !== 4'd9 || ovf !== 1'b0 || udf !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_dn: got count=%0d ovf=%b udf=%b expected 9 0 1", count, ovf, udf);
    end
    step(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (count !== 4'd9 || ovf !== 1'b0 || udf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold: got count=%0d ovf=%b udf=%b expected 9 0 0", count, ovf, udf);
    end
  endtask

`ifdef UPDN_CNT_STICKY_FLAG_EN
  task automatic test_sticky();
    step(0, 1, 0, 1, 9, 1);
    step(1, 1, 0, 0, 0, 0);
    n_tests++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set: got %b expected 1", ovf_sticky);
    end
    step(0, 1, 0, 0, 0, 0);
    n_tests++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_hold: got %b expected 1", ovf_sticky);
    end
    step(0, 1, 0, 0, 0, 1);
    n_tests++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clr: got %b expected 0", ovf_sticky);
    end
    step(0, 1, 0, 1, 9, 0);
    step(1, 1, 0, 0, 0, 1);
    n_tests++;
    if (ovf_sticky !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set_wins: got sticky=%b ovf=%b expected 1 1", ovf_sticky, ovf);
    end
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    n_tests++;
    if (udf_sticky !== 1'b1 || ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_udf: got udf_s=%b ovf_s=%b expected 1 0", udf_sticky, ovf_sticky);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (count !== 4'd0 || ovf !== 1'b0 || udf !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_rst[%0d]: got count=%0d ovf=%b udf=%b expected 0 0 0",
                   i, count, ovf, udf);
        end
        rst = 1'b1;
      end
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0);
      n_tests++;
      if (count !== W'(m_cnt) || ovf !== m_ovf || udf !== m_udf) begin
        n_fail++;
        $display("FAIL rand[%0d]: got count=%0d ovf=%b udf=%b expected %0d %b %b",
                 i, count, ovf, udf, m_cnt, m_ovf, m_udf);
      end
      n_tests++;
      if (ovf === 1'b1 && udf === 1'b1) begin
        n_fail++;
        $display("FAIL rand_both[%0d]: got ovf=1 udf=1 expected not both", i);
      end
`ifdef UPDN_CNT_STICKY_FLAG_EN
      n_tests++;
      if (ovf_sticky !== m_ovs || udf_sticky !== m_uds) begin
        n_fail++;
        $display("FAIL rand_sticky[%0d]: got %b %b expected %b %b",
                 i, ovf_sticky, udf_sticky, m_ovs, m_uds);
      end
`endif
    end
  endtask

  initial begin
    en       = 1'b0;
    up_dn    = 1'b1;
    sat_mode = 1'b0;
    load     = 1'b0;
    load_val = '0;
`ifdef UPDN_CNT_STICKY_FLAG_EN
    flag_clr = 1'b0;
`endif
    model_reset();
    test_reset();
    test_reset_mid_count();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_back_to_back();
`ifdef UPDN_CNT_STICKY_FLAG_EN
    test_sticky();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_updn_counter.md
PARAM_UPDN_COUNTER -- requirements
Module: param_updn_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal count; legal range 1..2**WIDTH-1.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  1  count enable; count advances only when high.
REQ-006 Port up_dn  input  1  direction; 1 = up, 0 = down.
REQ-007 Port sat_mode  input  1  boundary mode; 0 = wrap, 1 = saturate.
REQ-008 Port load  input  1  synchronous parallel load strobe.
REQ-009 Port load_val  input  WIDTH  value to load.
REQ-010 Port count  output  WIDTH  registered counter value.
REQ-011 Port ovf  output  1  registered one-cycle pulse, up-boundary event.
REQ-012 Port udf  output  1  registered one-cycle pulse, down-boundary event.
REQ-013 Port flag_clr  input  1  clears sticky flags; present only with macro, see Configuration.
REQ-014 Port ovf_sticky, udf_sticky  output  1 each  sticky boundary flags; present only with macro.

Function
REQ-015 Priority per edge SHALL be: load > en > hold.
REQ-016 load=1: count <= min(load_val, MAX_VAL); ovf/udf SHALL be 0 that cycle, regardless of en.
REQ-017 en=1, up_dn=1, count<MAX_VAL: count <= count+1.
REQ-018 en=1, up_dn=0, count>0: count <= count-1.
REQ-019 Up-boundary event = en=1, load=0, up_dn=1, count==MAX_VAL; next count SHALL be 0 if sat_mode=0, MAX_VAL if sat_mode=1.
REQ-020 Down-boundary event = en=1, load=0, up_dn=0, count==0; next count SHALL be MAX_VAL if sat_mode=0, 0 if sat_mode=1.
REQ-021 ovf SHALL be high for exactly the one cycle following an edge on which an up-boundary event occurred; udf likewise for down-boundary; both asserted in both modes.
REQ-022 ovf and udf SHALL never be high simultaneously.
REQ-023 en=0, load=0: count, ovf=0, udf=0 held/cleared per REQ-021; no other change.
REQ-024 up_dn and sat_mode SHALL be sampled every edge; a change takes effect on the same edge with no extra latency.
REQ-025 Arithmetic SHALL be WIDTH bits, unsigned; count SHALL never exceed MAX_VAL.
REQ-026 Latency: input change to count change = 1 clock edge.

Reset
REQ-027 rst low SHALL immediately force count=0, ovf=0, udf=0, and (if present) ovf_sticky=0, udf_sticky=0, independent of clk.
REQ-028 rst deasserted: first counting edge SHALL be the first rising clk edge with rst high; rst asserted mid-count SHALL discard in-progress state.

Configuration
REQ-029 Macro UPDN_CNT_STICKY_FLAG_EN SHALL control sticky flags.
REQ-030 With macro defined: ovf_sticky set on each ovf pulse edge, udf_sticky on each udf pulse edge; both held until flag_clr=1 on an edge; flag_clr concurrent with a new event SHALL leave the flag set (set wins).
REQ-031 Without macro: ports flag_clr, ovf_sticky, udf_sticky and their logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=4, MAX_VAL=9)
REQ-032 rst low mid-count at count=6 -> count=0, ovf=udf=0 before next clk edge; after release en=1 up -> 1,2,3.
REQ-033 sat_mode=0, up, en=1 from 0 for 11 edges -> 1..9,0,1; ovf high for one cycle after 9->0 only.
REQ-034 sat_mode=1, down from 2 for 4 edges -> 1,0,0,0; udf pulses after each of last two edges.
REQ-035 load=1, load_val=13, en=1 -> count=9, ovf=0; next edge up, sat_mode=0 -> count=0, ovf=1.
REQ-036 up at count=9 on one edge, down on next edge, sat_mode=0 -> count 0 then 9; ovf then udf, never together.
REQ-037 Macro defined: force ovf, then flag_clr=1 on an edge with no event -> ovf_sticky 1 then 0; flag_clr on an ovf edge -> ovf_sticky stays 1.
